uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver: 8N1 framing, LSB first, idle-high line.
- Recovers bytes driven onto a tx line, e.g. the o_tx output of the counter/transmitter top level, and presents them as parallel data with a one-cycle valid strobe.
- Sits at the chip boundary, after the pad; the input is asynchronous to clk.
- Fixed-ratio baud timing from the system clock. Mid-bit sampling, start-bit glitch rejection, framing-error detection.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit period (1 MHz clk / 9600 baud); legal range >= 4.
- SYNC_STAGES, 2, flops in the i_rx metastability synchronizer; legal range >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_enable  in  1  receiver enable; when low, no new frame is started.
- i_rx  in  1  serial input, asynchronous, idle high.
- o_data  out  8  last correctly framed byte; held until the next good frame.
- o_valid  out  1  one-cycle pulse: o_data updated this cycle.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - synchronizer flops = 1, state = IDLE, counters = 0.
  - o_data = 8'h00, o_valid = 0, o_frame_err = 0, o_busy = 0.
- rx_s is i_rx after SYNC_STAGES flops. All decisions use rx_s only.
- Bit counter: 0..CLKS_PER_BIT-1; wraps to 0 after reaching its terminal count. Bit index: 0..7.
- States:
  - IDLE:
    - If i_enable = 1 and rx_s = 0: go to START, bit counter = 0.
    - Otherwise stay in IDLE.
  - START:
    - At bit counter = (CLKS_PER_BIT-1)/2 (integer division), sample rx_s.
    - Sample = 0: go to DATA, bit counter = 0, bit index = 0.
    - Sample = 1: treat as a glitch; go to IDLE with no output pulse.
  - DATA:
    - At bit counter = CLKS_PER_BIT-1, shift rx_s into shift reg bit [index] (LSB first) and increment index.
    - After index 7 is captured, go to STOP with bit counter = 0.
  - STOP:
    - At bit counter = CLKS_PER_BIT-1, sample rx_s.
    - Sample = 1: o_data <= shift reg, o_valid = 1 for one cycle, go to IDLE.
    - Sample = 0: o_frame_err = 1 for one cycle, o_data unchanged, go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. A line held low (break condition) never produces spurious frames.
- Latency: o_valid rises SYNC_STAGES + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles (+/-1) after the i_rx falling edge.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. IDLE detects it on the first rx_s = 0 cycle, which costs at most 1 cycle of slip.
- i_enable deasserted mid-frame: the current frame completes normally. It only gates the IDLE->START transition.
- o_valid and o_frame_err are never high in the same cycle.
- Reset mid-frame: the partial byte is discarded, outputs return to reset values, and the next falling edge after release starts a new frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - 8E1 framing: a PARITY state sits between DATA and STOP and samples at CLKS_PER_BIT-1.
  - An extra output o_parity_err (1 bit, reset 0) pulses for one cycle alongside the stop-bit decision when the even parity of data+parity bit is wrong.
  - On parity error, o_valid still pulses and o_data still updates. A framing error takes priority: o_frame_err pulses, and neither o_valid nor o_parity_err pulses.
  - Latency grows by CLKS_PER_BIT.
- Undefined: 8N1 only; no PARITY state; no o_parity_err port.

Test Plan:
- CLKS_PER_BIT=16, i_enable=1, send 8'hA5 with a good stop bit -> o_valid pulses once, o_data=8'hA5, o_frame_err stays 0, o_busy falls with o_valid.
- Send 8'h3C then 8'hFF back to back (no idle gap) -> two o_valid pulses 160+/-1 cycles apart, o_data=8'h3C then 8'hFF.
- i_rx low pulse of 4 cycles (< half bit) -> no o_valid, no o_frame_err, o_busy returns to 0 within 8+SYNC_STAGES+1 cycles.
- Send 8'h55 with the stop bit driven 0, then hold i_rx low for 100 cycles, then release high -> one o_frame_err pulse; o_data keeps its previous value; no further pulses while low; next good byte 8'h12 is received correctly.
- i_enable=0 during a full frame of 8'h81 -> no o_valid. Enable mid-frame of a second byte -> that byte is not received. Third byte 8'h81 -> received.
- Assert i_reset_n=0 for 1 cycle during data bit 4 of 8'hF0 -> o_busy=0, o_data=8'h00 immediately. Next frame 8'h0F -> received as 8'h0F. With UART_RX_PARITY_EN: send 8'h07 with parity bit 0 -> o_valid and o_parity_err pulse together.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized serial input, mid-bit sampling, glitch and framing checks.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra o_parity_err pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   perr_q, perr_d;
`endif
    logic                   rx_s;
    logic                   cnt_last;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], i_rx};
    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_enable && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // A start bit that is high again by mid-bit is a line glitch.
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{shift_q, par_bit_q};
`endif
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a break never frames data.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
        end
    end

    assign o_parity_err = perr_q;
`endif

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule
